addsub_pipe: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; the datapath arithmetic primitive used inside the ALU.
- Generalises the fixed 4-bit ripple adder/subtractor to WIDTH bits. The carry chain is split across STAGES registered slices.
- Adds valid/ready flow control with backpressure and a registered status-flag output (carry, signed overflow, zero, negative).
- Throughput is one operation per cycle.

---
 rtl/addsub_pipe_if.sv | 29 ++
 rtl/addsub_pipe.sv | 178 +++++++++++++++++
 tb/tb_addsub_pipe.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_pipe_if.sv
// Handshake and data bundle for addsub_pipe.
// master: the side that supplies operands and consumes results.
// slave: the pipeline itself.
interface addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             m;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, m, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, m, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready flow control.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; slice k
// works on chunk k and hands its carry to slice k+1 one cycle later. The last
// slice's register is the output register, so a beat accepted on edge N is
// visible after edge N+STAGES-1. The whole pipe advances together whenever
// the output register is empty or being drained.
// Optional build macro: ADDSUB_PIPE_SATURATE_EN clamps overflowing results to
// the signed extreme in the last slice (ovf and cout still report raw values).
module addsub_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int C = WIDTH / STAGES;  // bits per slice
  localparam int L = STAGES - 1;      // index of the final slice

  // Per-stage registers: valid, operands travelling with the beat, partial sum
  // (finished lower chunks) and the carry out of that stage's slice.
  logic             vld_q [STAGES];
  logic             vld_d [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic             m_q   [STAGES];
  logic             m_d   [STAGES];
  logic [WIDTH-1:0] s_q   [STAGES];
  logic [WIDTH-1:0] s_d   [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;

  // What each slice sees on its input side.
  logic             src_vld [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic             src_m   [STAGES];
  logic [WIDTH-1:0] src_s   [STAGES];
  logic             src_c   [STAGES];

  // Slice results.
  logic [C:0]       res  [STAGES];
  logic [WIDTH-1:0] part [STAGES];
  logic             a_msb, bx_msb, c_msb, fin_ovf;
  logic [WIDTH-1:0] fin_sum;

  logic adv;

  function automatic logic [C:0] slice_add(input logic [C-1:0] x,
                                           input logic [C-1:0] y,
                                           input logic         cin);
    return {1'b0, x} + {1'b0, y} + (C+1)'(cin);
  endfunction

  // Global advance: everything moves unless a finished result is blocked.
  assign adv = !vld_q[L] || bus.out_ready;

  // Slice inputs: slice 0 takes the port beat with m as carry-in, later
  // slices take the register of the slice before them.
  always_comb begin
    src_vld[0] = bus.in_valid && adv;
    src_a[0]   = bus.a;
    src_b[0]   = bus.b;
    src_m[0]   = bus.m;
    src_s[0]   = '0;
    src_c[0]   = bus.m;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_m[k]   = m_q[k-1];
      src_s[k]   = s_q[k-1];
      src_c[k]   = c_q[k-1];
    end
  end

  // Slice arithmetic, final-slice flags and next-state for every register.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k];
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      m_d[k]   = m_q[k];
      s_d[k]   = s_q[k];
      c_d[k]   = c_q[k];
      res[k]   = slice_add(src_a[k][k*C +: C],
                           src_b[k][k*C +: C] ^ {C{src_m[k]}},
                           src_c[k]);
      part[k]  = src_s[k];
      part[k][k*C +: C] = res[k][C-1:0];
    end
    ovf_d  = ovf_q;
    zero_d = zero_q;
    neg_d  = neg_q;

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ bx ^ cin.
    a_msb   = src_a[L][WIDTH-1];
    bx_msb  = src_b[L][WIDTH-1] ^ src_m[L];
    c_msb   = part[L][WIDTH-1] ^ a_msb ^ bx_msb;
    fin_ovf = c_msb ^ res[L][C];
`ifdef ADDSUB_PIPE_SATURATE_EN
    // On overflow the true result has the sign of a; clamp toward it.
    fin_sum = fin_ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : part[L];
`else
    fin_sum = part[L];
`endif

    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_d[k] = src_vld[k];
        // Data only moves with a real beat, so bubbles never disturb it.
        if (src_vld[k]) begin
          a_d[k] = src_a[k];
          b_d[k] = src_b[k];
          m_d[k] = src_m[k];
          s_d[k] = part[k];
          c_d[k] = res[k][C];
        end
      end
      if (src_vld[L]) begin
        s_d[L] = fin_sum;
        ovf_d  = fin_ovf;
        zero_d = (fin_sum == '0);
        neg_d  = fin_sum[WIDTH-1];
      end
    end
  end

  // Control and visible-result registers: cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        s_q[k]   <= '0;
        c_q[k]   <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        s_q[k]   <= s_d[k];
        c_q[k]   <= c_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  // Operand registers travelling with each beat.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; contents are only consumed when the matching valid bit is set.
    for (int k = 0; k < STAGES; k++) begin
      a_q[k] <= a_d[k];
      b_q[k] <= b_d[k];
      m_q[k] <= m_d[k];
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[L];
  assign bus.sum       = s_q[L];
  assign bus.cout      = c_q[L];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Bench for addsub_pipe: three instances (16/4, 4/1, 32/8) driven from one
// directed sequence with random operands, checked against an exact-integer
// reference model and a per-instance ordered scoreboard.
// Honors ADDSUB_PIPE_SATURATE_EN in the reference model.
module tb_addsub_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic clk;
  logic rst_n;

  addsub_pipe_if #(.WIDTH(16)) bus16 ();
  addsub_pipe_if #(.WIDTH(4))  bus4  ();
  addsub_pipe_if #(.WIDTH(32)) bus32 ();

  addsub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  addsub_pipe #(.WIDTH(4),  .STAGES(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  addsub_pipe #(.WIDTH(32), .STAGES(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total;
  int   passed;
  int   cyc;
  int   wid [3];
  exp_t q [3][$];
  int   first_acc [3];
  int   first_ov  [3];
  int   last_ov   [3];
  int   acc       [3];
  int   dlv       [3];
  int   stalls    [3];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: exact integer arithmetic on the operands' values.
  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic m);
    exp_t        e;
    logic [63:0] mask, bx, tot;
    longint      sa, sb, ex, maxv, minv;
    mask   = (64'd1 << w) - 64'd1;
    a      = a & mask;
    b      = b & mask;
    bx     = m ? (~b & mask) : b;
    tot    = a + bx + 64'(m);
    e.sum  = tot & mask;
    e.cout = tot[w];
    sa     = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb     = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    ex     = m ? sa - sb : sa + sb;
    maxv   = (longint'(1) << (w-1)) - 1;
    minv   = -(longint'(1) << (w-1));
    e.ovf  = (ex > maxv) || (ex < minv);
`ifdef ADDSUB_PIPE_SATURATE_EN
    if (ex > maxv) e.sum = 64'(maxv);
    else if (ex < minv) e.sum = 64'(minv) & mask;
`endif
    e.zero = (e.sum == 64'd0);
    e.neg  = e.sum[w-1];
    return e;
  endfunction

  // Scoreboard step for one instance, sampled mid-cycle.
  task automatic sb(input int id, input logic iv, input logic ir, input logic ov,
                    input logic ordy, input logic [63:0] a, input logic [63:0] b,
                    input logic m, input logic [63:0] s, input logic [3:0] f);
    exp_t e;
    if (ov) begin
      if (first_ov[id] < 0) first_ov[id] = cyc;
      last_ov[id] = cyc;
      check($sformatf("beat_expected_d%0d", id), 64'(q[id].size() != 0), 64'd1);
      if (q[id].size() != 0) begin
        e = q[id][0];
        check($sformatf("sum_d%0d", id), s, e.sum);
        check($sformatf("flags_d%0d", id), 64'(f), 64'({e.cout, e.ovf, e.zero, e.neg}));
        if (ordy) begin
          void'(q[id].pop_front());
          dlv[id]++;
        end else begin
          stalls[id]++;
          check($sformatf("stall_in_ready_d%0d", id), 64'(ir), 64'd0);
        end
      end
    end
    if (iv && ir) begin
      q[id].push_back(model(wid[id], a, b, m));
      if (first_acc[id] < 0) first_acc[id] = cyc;
      acc[id]++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb(0, bus16.in_valid, bus16.in_ready, bus16.out_valid, bus16.out_ready,
       64'(bus16.a), 64'(bus16.b), bus16.m, 64'(bus16.sum),
       {bus16.cout, bus16.ovf, bus16.zero, bus16.neg});
    sb(1, bus4.in_valid, bus4.in_ready, bus4.out_valid, bus4.out_ready,
       64'(bus4.a), 64'(bus4.b), bus4.m, 64'(bus4.sum),
       {bus4.cout, bus4.ovf, bus4.zero, bus4.neg});
    sb(2, bus32.in_valid, bus32.in_ready, bus32.out_valid, bus32.out_ready,
       64'(bus32.a), 64'(bus32.b), bus32.m, 64'(bus32.sum),
       {bus32.cout, bus32.ovf, bus32.zero, bus32.neg});
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drv(input int id, input logic v, input logic [63:0] a, input logic [63:0] b,
                     input logic m);
    case (id)
      0:       begin bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.m = m; end
      1:       begin bus4.in_valid  = v; bus4.a  = a[3:0];  bus4.b  = b[3:0];  bus4.m  = m; end
      default: begin bus32.in_valid = v; bus32.a = a[31:0]; bus32.b = b[31:0]; bus32.m = m; end
    endcase
  endtask

  task automatic set_ordy(input int id, input logic r);
    case (id)
      0:       bus16.out_ready = r;
      1:       bus4.out_ready  = r;
      default: bus32.out_ready = r;
    endcase
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_all();
    for (int i = 0; i < 3; i++) begin
      drv(i, 1'b0, 64'd0, 64'd0, 1'b0);
      set_ordy(i, 1'b1);
    end
  endtask

  // Run with no new input until every scoreboard empties, bounded.
  task automatic drain();
    idle_all();
    for (int i = 0; i < 300 && (q[0].size() + q[1].size() + q[2].size()) != 0; i++) tick();
    for (int i = 0; i < 3; i++) check($sformatf("drained_d%0d", i), 64'(q[i].size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          d0, a0, sent, s0;
    logic [63:0] ca, cb;
    logic        cm;
    logic        before_acc;

    total  = 0;
    passed = 0;
    cyc    = 0;
    wid[0] = 16;
    wid[1] = 4;
    wid[2] = 32;
    for (int i = 0; i < 3; i++) begin
      first_acc[i] = -1; first_ov[i] = -1; last_ov[i] = -1;
      acc[i] = 0; dlv[i] = 0; stalls[i] = 0;
    end
    rst_n = 1'b0;
    idle_all();
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state.
    check("rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("rst_sum", 64'(bus16.sum), 64'd0);
    check("rst_flags", 64'({bus16.cout, bus16.ovf, bus16.zero, bus16.neg}), 64'd0);
    check("rst_in_ready", 64'(bus16.in_ready), 64'd1);
    check("rst_out_valid_d4", 64'(bus4.out_valid), 64'd0);
    check("rst_out_valid_d32", 64'(bus32.out_valid), 64'd0);

    // Directed corners: overflow, borrow, equal subtract, negative overflow.
    drv(0, 1'b1, 64'h7FFF, 64'h0001, 1'b0);
    drv(2, 1'b1, 64'h7FFF_FFFF, 64'h1, 1'b0);
    tick();
    drv(0, 1'b1, 64'h0005, 64'h0007, 1'b1);
    drv(2, 1'b1, 64'h8000_0000, 64'h1, 1'b1);
    tick();
    drv(0, 1'b1, 64'h1234, 64'h1234, 1'b1);
    drv(2, 1'b1, 64'hFFFF_FFFF, 64'h1, 1'b0);
    tick();
    drv(0, 1'b1, 64'h8000, 64'h0001, 1'b1);
    drv(2, 1'b0, 64'h0, 64'h0, 1'b0);
    tick();
    drv(0, 1'b1, 64'hFFFF, 64'hFFFF, 1'b0);
    tick();
    drain();

    // Latency and throughput: 8 back-to-back beats, out_ready held high.
    for (int i = 0; i < 2; i++) begin first_acc[i] = -1; first_ov[i] = -1; end
    d0 = dlv[0];
    for (int i = 0; i < 8; i++) begin
      drv(0, 1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
      drv(1, 1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
      tick();
    end
    drain();
    check("latency_d16", 64'(first_ov[0] - first_acc[0]), 64'd4);
    check("latency_d4", 64'(first_ov[1] - first_acc[1]), 64'd1);
    check("burst_span_d16", 64'(last_ov[0] - first_ov[0]), 64'd7);
    check("burst_count_d16", 64'(dlv[0] - d0), 64'd8);

    // Backpressure: 10 beats, out_ready low for 5 cycles mid-stream.
    d0   = dlv[0];
    a0   = acc[0];
    s0   = stalls[0];
    sent = 0;
    ca   = rnd64(); cb = rnd64(); cm = 1'($urandom_range(0, 1));
    for (int t = 0; t < 200 && !(sent == 10 && q[0].size() == 0); t++) begin
      set_ordy(0, !(t >= 6 && t < 11));
      drv(0, sent < 10, ca, cb, cm);
      before_acc = 1'b0;
      if (acc[0] != a0 + sent) before_acc = 1'b1;
      tick();
      if (acc[0] == a0 + sent + 1) begin
        sent++;
        ca = rnd64(); cb = rnd64(); cm = 1'($urandom_range(0, 1));
      end
    end
    drain();
    check("bp_accepted", 64'(acc[0] - a0), 64'd10);
    check("bp_delivered", 64'(dlv[0] - d0), 64'd10);
    check("bp_stall_cycles", 64'(stalls[0] - s0), 64'd5);

    // Reset mid-flight: 3 beats in, assert reset between edges.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b1, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
      tick();
    end
    drv(0, 1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    check("pre_rst_out_valid", 64'(bus16.out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(bus16.out_valid), 64'd0);
    check("mid_rst_sum", 64'(bus16.sum), 64'd0);
    check("mid_rst_flags", 64'({bus16.cout, bus16.ovf, bus16.zero, bus16.neg}), 64'd0);
    for (int i = 0; i < 3; i++) q[i].delete();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_idle", 64'(bus16.out_valid), 64'd0);
    end
    drv(0, 1'b1, 64'h00FF, 64'h0F01, 1'b0);
    tick();
    drain();

    // Random sweep on all three configurations with random backpressure.
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < 3; i++) begin
        drv(i, $urandom_range(0, 3) != 0, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
        set_ordy(i, $urandom_range(0, 9) < 7);
      end
      tick();
    end
    drain();
    check("sweep_balance_d4", 64'(acc[1] - dlv[1]), 64'd0);
    check("sweep_balance_d32", 64'(acc[2] - dlv[2]), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
